// File: rtl/spi_slave_responder_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI responder: FSM state encoding, STATUS bit
// positions, the default frame width and the synchroniser depth.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit positions inside STATUS
    localparam int ST_OVERRUN  = 0;
    localparam int ST_UNDERRUN = 1;
    localparam int ST_ABORT    = 2;
    localparam int ST_WFULL    = 3;

    localparam int DEFAULT_DATA_W = 8;

    // Flops between an asynchronous pin and its usable level
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/spi_slave_responder_pin_sync.sv
// -----------------------------------------------------------------------------
// spi_pin_sync
// Brings one asynchronous pin into the clk domain through SYNC_DEPTH flops.
// With EDGE_DET set, one more flop remembers the previous synchronised level
// and single-cycle rise/fall pulses are produced; without it the pulses are 0.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   pin   in   asynchronous input pin
//   level out  synchronised level
//   rise  out  one-cycle pulse on synchronised 0->1
//   fall  out  one-cycle pulse on synchronised 1->0
// -----------------------------------------------------------------------------
module spi_pin_sync
    import spi_pkg::*;
#(
    parameter bit EDGE_DET = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_DEPTH-2:0], pin};
        end
    end

    assign level = sync_reg[SYNC_DEPTH-1];

    generate
        if (EDGE_DET) begin : g_edge
            logic prev_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prev_reg <= 1'b0;
                end else begin
                    prev_reg <= level;
                end
            end

            assign rise = level & ~prev_reg;
            assign fall = ~level & prev_reg;
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_slave_responder.sv
// -----------------------------------------------------------------------------
// spi_slave_responder
// SPI slave end. Oversamples SCLK/SS_N/MOSI in the CLK domain, shifts a
// DATA_W-bit frame in and out, and offers one-deep TX/RX holding buffers
// with full flags plus sticky error flags in STATUS.
// Optional feature macro: SPI_SLAVE_RESPONDER_IRQ_EN (adds IRQ / IRQ_MASK).
// Ports:
//   CLK, CLR                    system clock, async active-high reset
//   SCLK, SS_N, MOSI            master pins (asynchronous)
//   MISO, MISO_OE               responder data out and its enable
//   TX_DATA, TX_WRITE           TX holding buffer write
//   TX_BUFFER_FULL_STATE        TX buffer occupied
//   RX_DATA, RX_READ            last received word and its consume strobe
//   RX_BUFFER_FULL_STATE        RX buffer occupied
//   BUSY                        frame in progress
//   STATUS, STATUS_CLR          sticky {wfull, abort, underrun, overrun}
//   IRQ, IRQ_MASK               (macro only) masked interrupt
// -----------------------------------------------------------------------------
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int                DATA_W    = DEFAULT_DATA_W,
    parameter bit                CPOL      = 1'b0,
    parameter bit                CPHA      = 1'b0,
    parameter logic [DATA_W-1:0] FILL_WORD = '1
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              SCLK,
    input  logic              SS_N,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_OE,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              TX_WRITE,
    output logic              TX_BUFFER_FULL_STATE,
    output logic [DATA_W-1:0] RX_DATA,
    input  logic              RX_READ,
    output logic              RX_BUFFER_FULL_STATE,
    output logic              BUSY,
    output logic [3:0]        STATUS,
    input  logic              STATUS_CLR
`ifdef SPI_SLAVE_RESPONDER_IRQ_EN
    ,
    output logic              IRQ,
    input  logic [5:0]        IRQ_MASK
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // ---------------- pin synchronisation ----------------
    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_pin_sync #(.EDGE_DET(1'b1)) u_sclk_sync (
        .clk(CLK), .rst(CLR), .pin(SCLK),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_sync #(.EDGE_DET(1'b1)) u_ss_sync (
        .clk(CLK), .rst(CLR), .pin(SS_N),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    spi_pin_sync #(.EDGE_DET(1'b0)) u_mosi_sync (
        .clk(CLK), .rst(CLR), .pin(MOSI),
        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    // Leading edge leaves the idle level CPOL, trailing edge returns to it.
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    // ---------------- registers ----------------
    state_t              state_reg,   state_next;
    logic [DATA_W-1:0]   shreg_reg,   shreg_next;
    logic [CNT_W-1:0]    cnt_reg,     cnt_next;
    logic                miso_reg,    miso_next;
    logic [DATA_W-1:0]   tx_buf_reg,  tx_buf_next;
    logic                tx_full_reg, tx_full_next;
    logic [DATA_W-1:0]   rx_data_reg, rx_data_next;
    logic                rx_full_reg, rx_full_next;
    logic [3:0]          status_reg,  status_next;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            cnt_reg     <= '0;
            miso_reg    <= 1'b0;
            tx_buf_reg  <= '0;
            tx_full_reg <= 1'b0;
            rx_data_reg <= '0;
            rx_full_reg <= 1'b0;
            status_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            shreg_reg   <= shreg_next;
            cnt_reg     <= cnt_next;
            miso_reg    <= miso_next;
            tx_buf_reg  <= tx_buf_next;
            tx_full_reg <= tx_full_next;
            rx_data_reg <= rx_data_next;
            rx_full_reg <= rx_full_next;
            status_reg  <= status_next;
        end
    end

    // ---------------- next state / datapath ----------------
    logic              load;
    logic [DATA_W-1:0] load_word;
    logic [3:0]        status_set;

    always_comb begin
        state_next   = state_reg;
        shreg_next   = shreg_reg;
        cnt_next     = cnt_reg;
        miso_next    = miso_reg;
        tx_buf_next  = tx_buf_reg;
        tx_full_next = tx_full_reg;
        rx_data_next = rx_data_reg;
        rx_full_next = rx_full_reg;
        status_set   = '0;
        load         = 1'b0;
        load_word    = tx_full_reg ? tx_buf_reg : FILL_WORD;

        if (RX_READ) begin
            rx_full_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (ss_fall) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    // Deselected mid-frame: the partial word is thrown away.
                    status_set[ST_ABORT] = 1'b1;
                    state_next           = IDLE;
                end else if (sample_edge) begin
                    shreg_next = {shreg_reg[DATA_W-2:0], mosi_s};
                    cnt_next   = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BIT) begin
                        state_next = DONE;
                    end
                end else if (shift_edge) begin
                    // Sampling shifts left, so the MSB is always the next bit
                    // owed to the master; this also makes the first CPHA=1
                    // shift edge present the MSB without advancing.
                    miso_next = shreg_reg[DATA_W-1];
                end
            end
            DONE: begin
                if (!rx_full_reg || RX_READ) begin
                    rx_data_next = shreg_reg;
                    rx_full_next = 1'b1;
                end else begin
                    status_set[ST_OVERRUN] = 1'b1;
                end
                if (ss_level) begin
                    state_next = IDLE;
                end else begin
                    load = 1'b1;   // back-to-back frame
                end
            end
            default: state_next = IDLE;
        endcase

        if (load) begin
            state_next   = SHIFT;
            cnt_next     = '0;
            shreg_next   = load_word;
            tx_full_next = 1'b0;
            if (!tx_full_reg) begin
                status_set[ST_UNDERRUN] = 1'b1;
            end
            if (CPHA == 1'b0) begin
                miso_next = load_word[DATA_W-1];
            end
        end

        // A write in a load cycle always lands, since the buffer is being
        // emptied on the same edge.
        if (TX_WRITE) begin
            if (!tx_full_reg || load) begin
                tx_buf_next  = TX_DATA;
                tx_full_next = 1'b1;
            end else begin
                status_set[ST_WFULL] = 1'b1;
            end
        end

        // Set events win over a simultaneous clear.
        status_next = (STATUS_CLR ? 4'b0000 : status_reg) | status_set;
    end

    // ---------------- outputs ----------------
    assign MISO                 = miso_reg;
    assign MISO_OE              = (state_reg != IDLE);
    assign BUSY                 = (state_reg != IDLE);
    assign TX_BUFFER_FULL_STATE = tx_full_reg;
    assign RX_DATA              = rx_data_reg;
    assign RX_BUFFER_FULL_STATE = rx_full_reg;
    assign STATUS               = status_reg;

`ifdef SPI_SLAVE_RESPONDER_IRQ_EN
    logic irq_reg;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |(IRQ_MASK & {~tx_full_reg, rx_full_reg, status_reg});
        end
    end

    assign IRQ = irq_reg;
`endif

endmodule

// File: tb/tb_spi_slave_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_responder
// Directed bench: one responder in mode 0 (CPOL=0,CPHA=0), one in mode 3
// (CPOL=1,CPHA=1). A behavioural master runs SCLK at CLK/16.
// -----------------------------------------------------------------------------
module tb_spi_slave_responder;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    logic       sclk_m [2];
    logic       ss_n_m [2];
    logic       mosi_m [2];
    logic       miso_w [2];
    logic       oe_w [2];
    logic [7:0] tx_data_m [2];
    logic       tx_write_m [2];
    logic       txf_w [2];
    logic [7:0] rx_data_w [2];
    logic       rx_read_m [2];
    logic       rxf_w [2];
    logic       busy_w [2];
    logic [3:0] status_w [2];
    logic       status_clr_m [2];
`ifdef SPI_SLAVE_RESPONDER_IRQ_EN
    logic       irq_w [2];
`endif

    spi_slave_responder #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .CLK(clk), .CLR(clr),
        .SCLK(sclk_m[0]), .SS_N(ss_n_m[0]), .MOSI(mosi_m[0]),
        .MISO(miso_w[0]), .MISO_OE(oe_w[0]),
        .TX_DATA(tx_data_m[0]), .TX_WRITE(tx_write_m[0]),
        .TX_BUFFER_FULL_STATE(txf_w[0]),
        .RX_DATA(rx_data_w[0]), .RX_READ(rx_read_m[0]),
        .RX_BUFFER_FULL_STATE(rxf_w[0]),
        .BUSY(busy_w[0]), .STATUS(status_w[0]), .STATUS_CLR(status_clr_m[0])
`ifdef SPI_SLAVE_RESPONDER_IRQ_EN
        , .IRQ(irq_w[0]), .IRQ_MASK(6'h00)
`endif
    );

    spi_slave_responder #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1)) dut1 (
        .CLK(clk), .CLR(clr),
        .SCLK(sclk_m[1]), .SS_N(ss_n_m[1]), .MOSI(mosi_m[1]),
        .MISO(miso_w[1]), .MISO_OE(oe_w[1]),
        .TX_DATA(tx_data_m[1]), .TX_WRITE(tx_write_m[1]),
        .TX_BUFFER_FULL_STATE(txf_w[1]),
        .RX_DATA(rx_data_w[1]), .RX_READ(rx_read_m[1]),
        .RX_BUFFER_FULL_STATE(rxf_w[1]),
        .BUSY(busy_w[1]), .STATUS(status_w[1]), .STATUS_CLR(status_clr_m[1])
`ifdef SPI_SLAVE_RESPONDER_IRQ_EN
        , .IRQ(irq_w[1]), .IRQ_MASK(6'h00)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // All drives happen 1 time unit after a rising CLK edge.
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_tx(input int m, input logic [7:0] d);
        tx_data_m[m]  = d;
        tx_write_m[m] = 1'b1;
        wait_clk(1);
        tx_write_m[m] = 1'b0;
        $display("tx_write m=%0d data=%02h", m, d);
    endtask

    task automatic pulse_rx_read(input int m);
        rx_read_m[m] = 1'b1;
        wait_clk(1);
        rx_read_m[m] = 1'b0;
    endtask

    task automatic pulse_status_clr(input int m);
        status_clr_m[m] = 1'b1;
        wait_clk(1);
        status_clr_m[m] = 1'b0;
    endtask

    // Master transfer of nbits (MSB first). Instance 0 runs mode 0, instance 1
    // mode 3. With raise_ss, SS_N goes high 1 CLK after the final sample edge
    // so the responder sees it deselected in its DONE cycle.
    task automatic xfer(input int m, input logic [7:0] mo, input int nbits,
                        input bit raise_ss, output logic [7:0] mi);
        logic cpol, cpha;
        logic [7:0] res;
        cpol = (m == 1);
        cpha = (m == 1);
        res  = '0;
        if (ss_n_m[m]) begin
            ss_n_m[m] = 1'b0;
            if (!cpha) mosi_m[m] = mo[7];
            wait_clk(8);
        end
        for (int i = 0; i < nbits; i++) begin
            sclk_m[m] = ~cpol;                      // leading edge
            if (!cpha) res[7-i] = miso_w[m];
            else       mosi_m[m] = mo[7-i];
            if (!cpha && raise_ss && i == nbits - 1) begin
                wait_clk(1); ss_n_m[m] = 1'b1; wait_clk(7);
            end else begin
                wait_clk(8);
            end
            sclk_m[m] = cpol;                       // trailing edge
            if (cpha) res[7-i] = miso_w[m];
            else if (i < nbits - 1) mosi_m[m] = mo[6-i];
            if (cpha && raise_ss && i == nbits - 1) begin
                wait_clk(1); ss_n_m[m] = 1'b1; wait_clk(7);
            end else begin
                wait_clk(8);
            end
        end
        mi = res;
        $display("xfer m=%0d bits=%0d mosi=%02h miso=%02h", m, nbits, mo, res);
    endtask

    logic [7:0] mi;

    initial begin
        sclk_m[0] = 1'b0; sclk_m[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ss_n_m[k] = 1'b1; mosi_m[k] = 1'b0; tx_data_m[k] = '0;
            tx_write_m[k] = 1'b0; rx_read_m[k] = 1'b0; status_clr_m[k] = 1'b0;
        end
        clr = 1'b1;
        wait_clk(3);
        clr = 1'b0;
        wait_clk(2);

        // Reset values
        check_val("rst_miso",   miso_w[0],    0);
        check_val("rst_oe",     oe_w[0],      0);
        check_val("rst_txf",    txf_w[0],     0);
        check_val("rst_rxf",    rxf_w[0],     0);
        check_val("rst_rxdata", rx_data_w[0], 0);
        check_val("rst_busy",   busy_w[0],    0);
        check_val("rst_status", status_w[0],  0);
        check_val("rst1_busy",  busy_w[1],    0);
        check_val("rst1_stat",  status_w[1],  0);

        // TX buffer, write-while-full, status clear
        write_tx(0, 8'hA5);
        check_val("txf_set", txf_w[0], 1);
        write_tx(0, 8'h11);
        check_val("wfull_status", status_w[0], 4'b1000);
        pulse_status_clr(0);
        check_val("status_clr", status_w[0], 0);

        // Mode 0 frame: TX A5, master sends 3C
        xfer(0, 8'h3C, 8, 1'b1, mi);
        wait_clk(4);
        check_val("m0_miso_word", mi,           8'hA5);
        check_val("m0_rxdata",    rx_data_w[0], 8'h3C);
        check_val("m0_rxf",       rxf_w[0],     1);
        check_val("m0_status",    status_w[0],  0);
        check_val("m0_txf",       txf_w[0],     0);
        check_val("m0_busy",      busy_w[0],    0);
        check_val("m0_oe",        oe_w[0],      0);
        pulse_rx_read(0);
        check_val("rx_read_clr", rxf_w[0], 0);

        // Underrun: no TX write, master sends 81
        xfer(0, 8'h81, 8, 1'b1, mi);
        wait_clk(4);
        check_val("ur_miso_word", mi,           8'hFF);
        check_val("ur_rxdata",    rx_data_w[0], 8'h81);
        check_val("ur_status",    status_w[0],  4'b0010);
        pulse_status_clr(0);
        pulse_rx_read(0);

        // Overrun: two frames with no RX_READ
        xfer(0, 8'h11, 8, 1'b1, mi);
        wait_clk(4);
        check_val("ov_rx1", rx_data_w[0], 8'h11);
        xfer(0, 8'h22, 8, 1'b1, mi);
        wait_clk(4);
        check_val("ov_rx2",    rx_data_w[0], 8'h11);
        check_val("ov_rxf",    rxf_w[0],     1);
        check_val("ov_status", status_w[0],  4'b0011);
        pulse_status_clr(0);
        pulse_rx_read(0);

        // Abort after 4 SCLK pulses
        xfer(0, 8'hC3, 4, 1'b0, mi);
        check_val("ab_busy_mid", busy_w[0], 1);
        check_val("ab_oe_mid",   oe_w[0],   1);
        ss_n_m[0] = 1'b1;
        wait_clk(3);
        check_val("ab_busy",   busy_w[0],   0);
        check_val("ab_status", status_w[0], 4'b0110);
        check_val("ab_rxf",    rxf_w[0],    0);
        wait_clk(8);

        // Mode 3: TX 5A, back-to-back F0 then 0F with RX_READ between
        write_tx(1, 8'h5A);
        xfer(1, 8'hF0, 8, 1'b0, mi);
        check_val("m3_miso1", mi,           8'h5A);
        check_val("m3_rx1",   rx_data_w[1], 8'hF0);
        check_val("m3_rxf1",  rxf_w[1],     1);
        pulse_rx_read(1);
        check_val("m3_rxf_rd", rxf_w[1], 0);
        xfer(1, 8'h0F, 8, 1'b1, mi);
        wait_clk(4);
        check_val("m3_miso2",  mi,           8'hFF);
        check_val("m3_rx2",    rx_data_w[1], 8'h0F);
        check_val("m3_rxf2",   rxf_w[1],     1);
        check_val("m3_status", status_w[1],  4'b0010);
        check_val("m3_busy",   busy_w[1],    0);

        // CLR mid-frame after 3 bits
        pulse_status_clr(0);
        xfer(0, 8'hE0, 3, 1'b0, mi);
        write_tx(0, 8'h99);
        clr = 1'b1;
        wait_clk(1);
        clr = 1'b0;
        check_val("clr_miso",   miso_w[0],    0);
        check_val("clr_oe",     oe_w[0],      0);
        check_val("clr_txf",    txf_w[0],     0);
        check_val("clr_rxf",    rxf_w[0],     0);
        check_val("clr_rxdata", rx_data_w[0], 0);
        check_val("clr_busy",   busy_w[0],    0);
        check_val("clr_status", status_w[0],  0);
        ss_n_m[0] = 1'b1;
        wait_clk(16);
        xfer(0, 8'h77, 8, 1'b1, mi);
        wait_clk(4);
        check_val("post_rxdata", rx_data_w[0], 8'h77);
        check_val("post_rxf",    rxf_w[0],     1);
        check_val("post_miso",   mi,           8'hFF);
        check_val("post_status", status_w[0],  4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
